// File: rtl/nexys_video_basic_io_pkg.sv
// nexys_video_basic_io_pkg: register map, sequencer states and AXI response codes for the basic I/O poller
package nexys_video_basic_io_pkg;
  localparam logic [7:0] REG_LED = 8'h00;
  localparam logic [7:0] REG_SW = 8'h08;
  localparam logic [7:0] REG_BTN = 8'h10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, SW_AR, SW_R, BTN_AR, BTN_R, LED_W, LED_B} state_t;
  function automatic logic [7:0] led_pattern(input logic [7:0] sw, input logic [4:0] btn);
    return sw ^ {3'b000, btn};
  endfunction
endpackage

// File: rtl/nexys_video_poll_timer.sv
// nexys_video_poll_timer: down-counter that reloads while idle and pulses expire after CYCLES running cycles
module nexys_video_poll_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] count;
  assign expire = run && count == W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= W'(CYCLES);
    else count <= (run && !expire) ? count - 1'b1 : W'(CYCLES);
endmodule

// File: rtl/nexys_video_basic_io_sequencer.sv
// nexys_video_basic_io_sequencer: AXI-Lite poller reading switches/buttons and writing their XOR to the LEDs;
// NEXYS_VIDEO_BASIC_IO_SEQ_ERR_CNT_EN adds a saturating error-response counter on o_err_cnt
module nexys_video_basic_io_sequencer
  import nexys_video_basic_io_pkg::*;
#(
  parameter int AXI_ID_WIDTH = 1,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int AXI_RESP_WIDTH = 2,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int POLL_CYCLES = 1000
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      i_enable,
  input  logic                      i_err_clr,
  output logic                      o_awvalid,
  input  logic                      i_awready,
  output logic [AXI_ID_WIDTH-1:0]   o_awid,
  output logic [AXI_ADDR_WIDTH-1:0] o_awaddr,
  output logic [2:0]                o_awprot,
  output logic                      o_wvalid,
  input  logic                      i_wready,
  output logic [AXI_DATA_WIDTH-1:0] o_wdata,
  output logic [AXI_STRB_WIDTH-1:0] o_wstrb,
  input  logic                      i_bvalid,
  output logic                      o_bready,
  input  logic [AXI_ID_WIDTH-1:0]   i_bid,
  input  logic [AXI_RESP_WIDTH-1:0] i_bresp,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [AXI_ID_WIDTH-1:0]   o_arid,
  output logic [AXI_ADDR_WIDTH-1:0] o_araddr,
  output logic [2:0]                o_arprot,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_ID_WIDTH-1:0]   i_rid,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [AXI_RESP_WIDTH-1:0] i_rresp,
  output logic                      o_busy,
  output logic                      o_poll_done,
  output logic [7:0]                o_switches,
  output logic [4:0]                o_buttons,
  output logic                      o_err
`ifdef NEXYS_VIDEO_BASIC_IO_SEQ_ERR_CNT_EN
  ,
  output logic [7:0]                o_err_cnt
`endif
);
  state_t state, state_nxt;
  logic expire, aw_done, w_done;
  logic aw_hs, w_hs, ar_hs, r_hs, b_hs, err_event;
  logic unused;
  assign unused = ^{i_bid, i_rid, i_rdata[AXI_DATA_WIDTH-1:8]};
  nexys_video_poll_timer #(.CYCLES(POLL_CYCLES)) u_timer (
    .clk(aclk),
    .rst(areset),
    .run(state == IDLE && i_enable),
    .expire(expire)
  );
  assign o_arvalid = state == SW_AR || state == BTN_AR;
  assign o_araddr = BASE_ADDR + AXI_ADDR_WIDTH'(state == BTN_AR ? REG_BTN : REG_SW);
  assign o_arid = '0;
  assign o_arprot = 3'b000;
  assign o_rready = state == SW_R || state == BTN_R;
  assign o_awvalid = state == LED_W && !aw_done;
  assign o_awaddr = BASE_ADDR + AXI_ADDR_WIDTH'(REG_LED);
  assign o_awid = '0;
  assign o_awprot = 3'b000;
  assign o_wvalid = state == LED_W && !w_done;
  assign o_wdata = {{(AXI_DATA_WIDTH - 8){1'b0}}, led_pattern(o_switches, o_buttons)};
  assign o_wstrb = '1;
  assign o_bready = state == LED_B;
  assign o_busy = state != IDLE;
  assign aw_hs = o_awvalid && i_awready;
  assign w_hs = o_wvalid && i_wready;
  assign ar_hs = o_arvalid && i_arready;
  assign r_hs = o_rready && i_rvalid;
  assign b_hs = o_bready && i_bvalid;
  assign o_poll_done = b_hs;
  assign err_event = (r_hs && i_rresp != AXI_RESP_WIDTH'(RESP_OKAY)) ||
                     (b_hs && i_bresp != AXI_RESP_WIDTH'(RESP_OKAY));
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = expire ? SW_AR : IDLE;
      SW_AR:   state_nxt = ar_hs ? SW_R : SW_AR;
      SW_R:    state_nxt = r_hs ? BTN_AR : SW_R;
      BTN_AR:  state_nxt = ar_hs ? BTN_R : BTN_AR;
      BTN_R:   state_nxt = r_hs ? LED_W : BTN_R;
      LED_W:   state_nxt = (aw_done || aw_hs) && (w_done || w_hs) ? LED_B : LED_W;
      LED_B:   state_nxt = b_hs ? IDLE : LED_B;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else state <= state_nxt;
  // done flags only live inside LED_W so the next write starts with both channels pending
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      aw_done <= state_nxt == LED_W && (aw_done || aw_hs);
      w_done <= state_nxt == LED_W && (w_done || w_hs);
    end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      o_switches <= '0;
      o_buttons <= '0;
    end else begin
      if (r_hs && state == SW_R) o_switches <= i_rdata[7:0];
      if (r_hs && state == BTN_R) o_buttons <= i_rdata[4:0];
    end
  always_ff @(posedge aclk or posedge areset)
    if (areset) o_err <= 1'b0;
    else if (err_event) o_err <= 1'b1;
    else if (i_err_clr) o_err <= 1'b0;
`ifdef NEXYS_VIDEO_BASIC_IO_SEQ_ERR_CNT_EN
  always_ff @(posedge aclk or posedge areset)
    if (areset) o_err_cnt <= '0;
    else if (err_event) o_err_cnt <= o_err_cnt == 8'hFF ? o_err_cnt : o_err_cnt + 8'd1;
    else if (i_err_clr) o_err_cnt <= '0;
`endif
endmodule
